// File: rtl/mini_cpu_pkg.sv
// Shared opcodes, sequencer state encoding and the jump-offset sign extender
// for the mini CPU core.
package mini_cpu_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_LW  = 2'd1;
    localparam logic [1:0] OP_SW  = 2'd2;
    localparam logic [1:0] OP_J   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    // Sign-extends the low field_w bits of field; callers truncate to the PC width.
    function automatic logic [31:0] sext(input logic [31:0] field, input int field_w);
        logic [31:0] r;
        r = field;
        for (int i = 0; i < 32; i++) begin
            if (i >= field_w) r[i] = field[field_w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/mini_cpu_regfile.sv
// Register file: two operand read ports, one write port and a combinational
// debug read port; all registers clear on reset.
module mini_cpu_regfile #(
    parameter int FIELD_W = 2,
    parameter int DATA_W  = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [FIELD_W-1:0] ra_addr_i,
    input  logic [FIELD_W-1:0] rb_addr_i,
    input  logic               wr_en_i,
    input  logic [FIELD_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]  wr_data_i,
    input  logic [FIELD_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0]  ra_data_o,
    output logic [DATA_W-1:0]  rb_data_o,
    output logic [DATA_W-1:0]  dbg_data_o
);

    localparam int NREG = 2 ** FIELD_W;

    logic [DATA_W-1:0] regs_q [NREG];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wr_en_i) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Reads see the pre-edge value when a write targets the same register.
    assign ra_data_o  = regs_q[ra_addr_i];
    assign rb_data_o  = regs_q[rb_addr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/mini_cpu_core.sv
// Multi-cycle core with writable imem, regfile, dmem, run/step control and debug read.
// state  | meaning
// IDLE   | waiting for run or step; imem may be loaded
// FETCH  | ir <= imem[pc]
// DECODE | latch reg[a], reg[b]
// EXEC   | add sum or effective address; j updates pc and finishes
// MEM    | lw reads dmem; sw writes dmem, pc+1 and finishes
// WB     | register write, pc+1 and finish
module mini_cpu_core
    import mini_cpu_pkg::*;
#(
    parameter int FIELD_W    = 2,
    parameter int DATA_W     = 8,
    parameter int IMEM_DEPTH = 32,
    parameter int DMEM_DEPTH = 16,
    localparam int IW = 4 * FIELD_W,
    localparam int PW = $clog2(IMEM_DEPTH),
    localparam int DW = $clog2(DMEM_DEPTH)
) (
    input  logic               clk50,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic               prog_we,
    input  logic [PW-1:0]      prog_addr,
    input  logic [IW-1:0]      prog_data,
    input  logic [FIELD_W-1:0] dbg_sel,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [PW-1:0]      pc,
    output logic               busy,
    output logic               retire,
    output logic               carry,
    output logic               prog_err
);

    state_t             state_q;
    logic [PW-1:0]      pc_q;
    logic [IW-1:0]      ir_q;
    logic [DATA_W-1:0]  opa_q;
    logic [DATA_W-1:0]  opb_q;
    logic [DATA_W-1:0]  mdr_q;
    logic [DATA_W:0]    alu_q;
    logic [DW-1:0]      ea_q;
    logic               carry_q;
    logic               retire_q;
    logic               prog_err_q;
    logic [IW-1:0]      imem_q [IMEM_DEPTH];
    logic [DATA_W-1:0]  dmem_q [DMEM_DEPTH];

    logic [FIELD_W-1:0] ir_op, ir_a, ir_b, ir_c;
    logic               is_add, is_lw, is_sw, is_j;
    logic [DATA_W-1:0]  ra_data, rb_data, rf_wdata;
    logic [FIELD_W-1:0] rf_waddr;
    logic               rf_we;
    logic [PW-1:0]      pc_inc, pc_jmp;
    logic [DW-1:0]      ea_d;
    state_t             done_state;

    assign ir_op = ir_q[IW-1 -: FIELD_W];
    assign ir_a  = ir_q[3*FIELD_W-1 -: FIELD_W];
    assign ir_b  = ir_q[2*FIELD_W-1 -: FIELD_W];
    assign ir_c  = ir_q[FIELD_W-1:0];

    assign is_add = (ir_op == FIELD_W'(OP_ADD));
    assign is_lw  = (ir_op == FIELD_W'(OP_LW));
    assign is_sw  = (ir_op == FIELD_W'(OP_SW));
    assign is_j   = (ir_op == FIELD_W'(OP_J));

    assign pc_inc = pc_q + PW'(1);
    // A zero offset would spin on itself, so j with c=0 behaves as a NOP.
    assign pc_jmp = (ir_c == '0) ? pc_inc : pc_q + PW'(sext(32'(ir_c), FIELD_W));
    assign ea_d   = DW'(opa_q + DATA_W'(ir_c));

    assign done_state = run ? S_FETCH : S_IDLE;

    assign rf_we    = (state_q == S_WB);
    assign rf_waddr = is_lw ? ir_b : ir_c;
    assign rf_wdata = is_lw ? mdr_q : alu_q[DATA_W-1:0];

    mini_cpu_regfile #(
        .FIELD_W (FIELD_W),
        .DATA_W  (DATA_W)
    ) u_regfile (
        .clk_i      (clk50),
        .rst_n_i    (reset),
        .ra_addr_i  (ir_a),
        .rb_addr_i  (ir_b),
        .wr_en_i    (rf_we),
        .wr_addr_i  (rf_waddr),
        .wr_data_i  (rf_wdata),
        .dbg_addr_i (dbg_sel),
        .ra_data_o  (ra_data),
        .rb_data_o  (rb_data),
        .dbg_data_o (dbg_data)
    );

    // The loaded program must survive reset, so imem has no reset branch.
    always_ff @(posedge clk50) begin
        if (prog_we && state_q == S_IDLE) imem_q[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            mdr_q      <= '0;
            alu_q      <= '0;
            ea_q       <= '0;
            carry_q    <= 1'b0;
            retire_q   <= 1'b0;
            prog_err_q <= 1'b0;
            for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= DATA_W'(i);
        end else begin
            retire_q   <= 1'b0;
            prog_err_q <= prog_we && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (run || step) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    ir_q    <= imem_q[pc_q];
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    opa_q   <= ra_data;
                    opb_q   <= rb_data;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_add) begin
                        alu_q   <= {1'b0, opa_q} + {1'b0, opb_q};
                        state_q <= S_WB;
                    end else if (is_lw || is_sw) begin
                        ea_q    <= ea_d;
                        state_q <= S_MEM;
                    end else if (is_j) begin
                        pc_q     <= pc_jmp;
                        retire_q <= 1'b1;
                        state_q  <= done_state;
                    end else begin
                        pc_q     <= pc_inc;
                        retire_q <= 1'b1;
                        state_q  <= done_state;
                    end
                end
                S_MEM: begin
                    if (is_lw) begin
                        mdr_q   <= dmem_q[ea_q];
                        state_q <= S_WB;
                    end else begin
                        dmem_q[ea_q] <= opb_q;
                        pc_q         <= pc_inc;
                        retire_q     <= 1'b1;
                        state_q      <= done_state;
                    end
                end
                S_WB: begin
                    if (is_add) carry_q <= carry_q | alu_q[DATA_W];
                    pc_q     <= pc_inc;
                    retire_q <= 1'b1;
                    state_q  <= done_state;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pc       = pc_q;
    assign busy     = (state_q != S_IDLE);
    assign retire   = retire_q;
    assign carry    = carry_q;
    assign prog_err = prog_err_q;

endmodule

// File: tb/tb_mini_cpu_core.sv
// Scoreboard bench for mini_cpu_core: an ISA-level model predicts pc, carry and
// registers for every instruction; a monitor compares them on each retire pulse.
module tb_mini_cpu_core;

    logic       clk50 = 1'b0;
    logic       reset;
    logic       run;
    logic       step;
    logic       prog_we;
    logic [4:0] prog_addr;
    logic [7:0] prog_data;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;
    logic [4:0] pc;
    logic       busy;
    logic       retire;
    logic       carry;
    logic       prog_err;

    mini_cpu_core dut (
        .clk50     (clk50),
        .reset     (reset),
        .run       (run),
        .step      (step),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data),
        .pc        (pc),
        .busy      (busy),
        .retire    (retire),
        .carry     (carry),
        .prog_err  (prog_err)
    );

    always #10 clk50 = ~clk50;

    typedef struct packed {
        logic [4:0]  pc;
        logic        carry;
        logic [31:0] regs;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          retire_cnt = 0;
    logic [31:0] cur_regs = '0;

    logic [7:0] m_imem [32];
    logic [7:0] m_dmem [16];
    logic [7:0] m_reg  [4];
    logic [4:0] m_pc;
    logic       m_carry;

    // Monitor: snapshot all registers through the debug port, then check retires.
    always @(negedge clk50) begin
        logic [31:0] v;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            v[i*8 +: 8] = dbg_data;
        end
        cur_regs = v;
        if (reset === 1'b1 && retire === 1'b1) begin
            retire_cnt++;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_retire pc=%0d", pc);
            end else begin
                e = sb.pop_front();
                if (pc !== e.pc || carry !== e.carry || v !== e.regs) begin
                    n_fail++;
                    $display("FAIL retire_state pc=%0d/%0d carry=%0b/%0b regs=%h/%h (got/exp)",
                             pc, e.pc, carry, e.carry, v, e.regs);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk50);
        #6;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_dmem[i] = 8'(i);
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_pc = 5'd0;
        m_carry = 1'b0;
        sb.delete();
    endtask

    task automatic model_exec();
        logic [7:0] ins, ra, rb, ea;
        logic [1:0] op, a, b, c;
        logic [8:0] sum;
        exp_t e;
        ins = m_imem[m_pc];
        op = ins[7:6]; a = ins[5:4]; b = ins[3:2]; c = ins[1:0];
        ra = m_reg[a];
        rb = m_reg[b];
        ea = ra + {6'd0, c};
        case (op)
            2'd0: begin
                sum = {1'b0, ra} + {1'b0, rb};
                m_reg[c] = sum[7:0];
                m_carry = m_carry | sum[8];
                m_pc = m_pc + 5'd1;
            end
            2'd1: begin m_reg[b] = m_dmem[ea[3:0]]; m_pc = m_pc + 5'd1; end
            2'd2: begin m_dmem[ea[3:0]] = rb; m_pc = m_pc + 5'd1; end
            default: m_pc = (c == 2'd0) ? m_pc + 5'd1 : m_pc + {{3{c[1]}}, c};
        endcase
        e.pc = m_pc;
        e.carry = m_carry;
        e.regs = {m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        tick();
        model_reset();
        reset = 1'b1;
        tick();
    endtask

    task automatic load_word(input logic [4:0] addr, input logic [7:0] data);
        prog_addr = addr;
        prog_data = data;
        prog_we = 1'b1;
        tick();
        prog_we = 1'b0;
        m_imem[addr] = data;
    endtask

    task automatic run_prog(input int n, output int got);
        int start, cyc;
        for (int k = 0; k < n; k++) model_exec();
        start = retire_cnt;
        cyc = 0;
        run = 1'b1;
        while ((retire_cnt - start) < n && cyc < 10 * n + 20) begin
            tick();
            cyc++;
            if ((retire_cnt - start) >= n - 1) run = 1'b0;
        end
        run = 1'b0;
        repeat (8) tick();
        got = retire_cnt - start;
    endtask

    task automatic step_one(output int lat);
        int start;
        model_exec();
        start = retire_cnt;
        step = 1'b1;
        tick();
        step = 1'b0;
        lat = 1;
        while (retire_cnt == start && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        n_tests++;
        if (pc !== 5'd0 || busy !== 1'b0 || retire !== 1'b0 || carry !== 1'b0 || prog_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs pc=%0d busy=%0b retire=%0b carry=%0b prog_err=%0b", pc, busy, retire, carry, prog_err);
        end
        n_tests++;
        if (cur_regs !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs got=%h exp=0", cur_regs);
        end
        model_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (busy !== 1'b0 || pc !== 5'd0 || retire_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_idle busy=%0b pc=%0d retires=%0d", busy, pc, retire_cnt);
        end
    endtask

    task automatic test_load_run();
        int got;
        load_word(5'd0, 8'h49);
        load_word(5'd1, 8'h18);
        run_prog(2, got);
        n_tests++;
        if (got != 2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_run_retires got=%0d exp=2 busy=%0b", got, busy);
        end
        n_tests++;
        if (pc !== 5'd2 || cur_regs[7:0] !== 8'h01 || cur_regs[23:16] !== 8'h01) begin
            n_fail++;
            $display("FAIL load_run_result pc=%0d reg0=%h reg2=%h exp 2,01,01", pc, cur_regs[7:0], cur_regs[23:16]);
        end
    endtask

    task automatic test_mem();
        int got;
        load_word(5'd2, 8'hA9);
        load_word(5'd3, 8'h4D);
        run_prog(2, got);
        n_tests++;
        if (got != 2 || pc !== 5'd4 || cur_regs[31:24] !== 8'h01) begin
            n_fail++;
            $display("FAIL mem_sw_lw retires=%0d pc=%0d reg3=%h exp 2,4,01", got, pc, cur_regs[31:24]);
        end
    endtask

    task automatic test_jump();
        int got;
        apply_reset();
        for (int i = 0; i < 11; i++) load_word(5'(i), 8'hC0);
        load_word(5'd11, 8'hC2);
        run_prog(13, got);
        n_tests++;
        if (got != 13 || pc !== 5'd10) begin
            n_fail++;
            $display("FAIL jump_back retires=%0d pc=%0d exp 13,10", got, pc);
        end
        apply_reset();
        load_word(5'd0, 8'hC3);
        load_word(5'd31, 8'hC1);
        run_prog(2, got);
        n_tests++;
        if (got != 2 || pc !== 5'd0) begin
            n_fail++;
            $display("FAIL jump_wrap retires=%0d pc=%0d exp 2,0", got, pc);
        end
    endtask

    task automatic test_carry();
        int got;
        logic [7:0] prog [14] = '{8'h47, 8'h57, 8'h57, 8'h57, 8'h57, 8'h15, 8'h15,
                                   8'h15, 8'h15, 8'h84, 8'h48, 8'h1B, 8'h00, 8'h04};
        apply_reset();
        for (int i = 0; i < 14; i++) load_word(5'(i), prog[i]);
        run_prog(14, got);
        n_tests++;
        if (got != 14 || pc !== 5'd14) begin
            n_fail++;
            $display("FAIL carry_prog retires=%0d pc=%0d exp 14,14", got, pc);
        end
        n_tests++;
        if (cur_regs !== 32'hE0F0F0F0 || carry !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_sticky regs=%h carry=%0b exp e0f0f0f0,1", cur_regs, carry);
        end
    endtask

    task automatic test_step_mode();
        int lat, start, cyc, t1;
        int exp_lat [4] = '{6, 5, 5, 4};
        logic [7:0] prog [8] = '{8'h47, 8'h15, 8'h84, 8'hC1, 8'hC1, 8'hC1, 8'hC1, 8'hC3};
        apply_reset();
        for (int i = 0; i < 8; i++) load_word(5'(i), prog[i]);
        for (int k = 0; k < 4; k++) begin
            step_one(lat);
            n_tests++;
            if (lat != exp_lat[k]) begin
                n_fail++;
                $display("FAIL step_latency instr=%0d got=%0d exp=%0d", k, lat, exp_lat[k]);
            end
            start = retire_cnt;
            repeat (6) tick();
            n_tests++;
            if (retire_cnt != start || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL step_single instr=%0d extra=%0d busy=%0b", k, retire_cnt - start, busy);
            end
        end
        model_exec();
        model_exec();
        start = retire_cnt;
        t1 = -1;
        cyc = 0;
        step = 1'b1;
        while ((retire_cnt - start) < 2 && cyc < 40) begin
            tick();
            cyc++;
            if ((retire_cnt - start) == 1 && t1 < 0) t1 = cyc;
        end
        step = 1'b0;
        repeat (6) tick();
        n_tests++;
        if ((retire_cnt - start) != 2 || cyc - t1 != 4 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL step_held retires=%0d gap=%0d busy=%0b exp 2,4,0", retire_cnt - start, cyc - t1, busy);
        end
        model_exec();
        start = retire_cnt;
        step = 1'b1;
        tick();
        step = 1'b0;
        prog_addr = 5'd7;
        prog_data = 8'hC0;
        prog_we = 1'b1;
        tick();
        prog_we = 1'b0;
        n_tests++;
        if (prog_err !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL prog_err_pulse prog_err=%0b busy=%0b exp 1,1", prog_err, busy);
        end
        tick();
        n_tests++;
        if (prog_err !== 1'b0) begin
            n_fail++;
            $display("FAIL prog_err_width prog_err=%0b exp 0", prog_err);
        end
        cyc = 0;
        while (retire_cnt == start && cyc < 20) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        step_one(lat);
        repeat (4) tick();
        n_tests++;
        if (pc !== 5'd6 || lat != 4) begin
            n_fail++;
            $display("FAIL imem_protect pc=%0d lat=%0d exp 6,4", pc, lat);
        end
    endtask

    task automatic test_reset_abort();
        int lat, start;
        apply_reset();
        load_word(5'd0, 8'h47);
        load_word(5'd1, 8'h16);
        step_one(lat);
        repeat (3) tick();
        model_exec();
        start = retire_cnt;
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (busy !== 1'b1 || cur_regs[15:8] !== 8'h03) begin
            n_fail++;
            $display("FAIL abort_setup busy=%0b reg1=%h exp 1,03", busy, cur_regs[15:8]);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (pc !== 5'd0 || busy !== 1'b0 || retire !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async pc=%0d busy=%0b retire=%0b exp 0,0,0", pc, busy, retire);
        end
        tick();
        tick();
        model_reset();
        reset = 1'b1;
        repeat (4) tick();
        n_tests++;
        if (cur_regs !== 32'h0 || retire_cnt != start || pc !== 5'd0) begin
            n_fail++;
            $display("FAIL abort_no_commit regs=%h retires=%0d pc=%0d exp 0,0,0", cur_regs, retire_cnt - start, pc);
        end
        step_one(lat);
        repeat (3) tick();
        n_tests++;
        if (cur_regs[15:8] !== 8'h03 || pc !== 5'd1) begin
            n_fail++;
            $display("FAIL abort_imem_kept reg1=%h pc=%0d exp 03,1", cur_regs[15:8], pc);
        end
    endtask

    initial begin
        reset = 1'b0;
        run = 1'b0;
        step = 1'b0;
        prog_we = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        for (int i = 0; i < 32; i++) m_imem[i] = 8'hxx;
        model_reset();
        tick();
        test_reset();
        test_load_run();
        test_mem();
        test_jump();
        test_carry();
        test_step_mode();
        test_reset_abort();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover pending=%0d exp 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
